// File: rtl/clock_period_monitor_if.sv
// clock_period_monitor_if
//   Result handshake between the clock period monitor and its consumer.
//   period_out   : cycles between consecutive rising edges of the monitored clock
//   high_out     : cycles from a rising edge to the following falling edge
//   result_valid : period_out/high_out hold an unacknowledged result
//   result_ack   : consumer acknowledge, clears result_valid
//   master = monitor side, slave = consumer side.
interface clock_period_monitor_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] period_out;
   logic [WIDTH-1:0] high_out;
   logic             result_valid;
   logic             result_ack;

   modport master (
      output period_out,
      output high_out,
      output result_valid,
      input  result_ack
   );

   modport slave (
      input  period_out,
      input  high_out,
      input  result_valid,
      output result_ack
   );
endinterface

// File: rtl/clock_period_monitor.sv
// clock_period_monitor
//   Measures a slow clock (sample_in) as data in the clock_in domain and
//   reports its period and high time in clock_in cycles. Raises stalled when
//   no rising edge is seen within TIMEOUT cycles.
// Ports:
//   clock_in  : system clock, all logic on its rising edge
//   reset     : synchronous, active-high reset
//   enable    : level-sensitive measurement enable
//   sample_in : monitored slow clock, asynchronous to clock_in
//   res       : result handshake (period_out, high_out, result_valid, result_ack)
//   overrun   : sticky, an unacknowledged result was overwritten
//   stalled   : no rising edge within TIMEOUT cycles
module clock_period_monitor #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic                   clock_in,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   sample_in,
   clock_period_monitor_if.master res,
   output logic                   overrun,
   output logic                   stalled
);

   localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE
   } state_t;

   state_t           state;
   state_t           state_next;

   logic             s1;
   logic             s2;
   logic             s3;
   logic             rise;
   logic             fall;

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] high_shadow;
   logic             stalled_next;
   logic             latch;
   logic             capture_high;

   // s1/s2 resynchronise sample_in; s3 is the previous synchronised value
   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A rise always wins over the timeout check, so a period of exactly
   // TIMEOUT cycles is still measured.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      stalled_next = stalled;
      latch        = 1'b0;
      capture_high = 1'b0;
      if (!enable) begin
         state_next   = IDLE;
         cnt_next     = '0;
         stalled_next = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state_next   = ARM;
               cnt_next     = '0;
               stalled_next = 1'b0;
            end
            ARM: begin
               if (rise) begin
                  cnt_next   = WIDTH'(1);
                  state_next = MEASURE;
               end else if (cnt == TIMEOUT_CNT) begin
                  stalled_next = 1'b1;
                  cnt_next     = '0;
               end else begin
                  cnt_next = cnt + WIDTH'(1);
               end
            end
            MEASURE: begin
               if (rise) begin
                  latch        = 1'b1;
                  stalled_next = 1'b0;
                  cnt_next     = WIDTH'(1);
               end else if (cnt == TIMEOUT_CNT) begin
                  stalled_next = 1'b1;
                  cnt_next     = '0;
                  state_next   = ARM;
               end else begin
                  cnt_next     = cnt + WIDTH'(1);
                  capture_high = fall;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         s1               <= 1'b0;
         s2               <= 1'b0;
         s3               <= 1'b0;
         cnt              <= '0;
         high_shadow      <= '0;
         stalled          <= 1'b0;
         overrun          <= 1'b0;
         res.period_out   <= '0;
         res.high_out     <= '0;
         res.result_valid <= 1'b0;
      end else begin
         s1      <= sample_in;
         s2      <= s1;
         s3      <= s2;
         cnt     <= cnt_next;
         stalled <= stalled_next;
         if (capture_high) begin
            high_shadow <= cnt;
         end
         // A latch coinciding with an ack keeps valid high without overrun
         if (latch) begin
            res.period_out   <= cnt;
            res.high_out     <= high_shadow;
            res.result_valid <= 1'b1;
            if (res.result_valid && !res.result_ack) begin
               overrun <= 1'b1;
            end
         end else if (res.result_ack) begin
            res.result_valid <= 1'b0;
         end
      end
   end

endmodule
